// File: rtl/pet_loader_pkg.sv
// Shared types and default parameters for the PRG download sequencer.
package pet_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    FIX,
    DONE
  } loader_state_t;

  localparam logic [7:0]  PRG_INDEX_DEF = 8'h41;
  localparam logic [15:0] RAM_TOP_DEF   = 16'h8000;
  localparam logic [15:0] PTR_BASE_DEF  = 16'h002A;
  localparam int unsigned PTR_COUNT_DEF = 3;

  // Pointer fixup byte k carries the low byte of the end address when k is even.
  function automatic logic [7:0] fix_byte(input logic [15:0] end_addr, input logic odd);
    return odd ? end_addr[15:8] : end_addr[7:0];
  endfunction

endpackage

// File: rtl/loader_dma_slot.sv
// Single-entry write holding register: keeps a RAM write request stable until acknowledged.
module loader_dma_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  input  logic        ack,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        pending,
  output logic        ioctl_wait
);

  // A load is only accepted while empty, so an unacknowledged request is never replaced.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_we   <= 1'b0;
      dma_addr <= 16'h0000;
      dma_din  <= 8'h00;
    end else if (!dma_we && load) begin
      dma_we   <= 1'b1;
      dma_addr <= load_addr;
      dma_din  <= load_data;
    end else if (dma_we && ack) begin
      dma_we <= 1'b0;
    end
  end

  assign pending    = dma_we;
  assign ioctl_wait = dma_we;

endmodule

// File: rtl/prg_loader.sv
// Streams a PRG download into PET RAM over the DMA port, then patches the BASIC end pointers.
module prg_loader
  import pet_loader_pkg::*;
#(
  parameter logic [7:0]  PRG_INDEX = PRG_INDEX_DEF,
  parameter logic [15:0] RAM_TOP   = RAM_TOP_DEF,
  parameter logic [15:0] PTR_BASE  = PTR_BASE_DEF,
  parameter int unsigned PTR_COUNT = PTR_COUNT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  input  logic        dma_ack,
  output logic        cpu_hold,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned FIX_N = 2 * PTR_COUNT;
  localparam int unsigned FIX_W = (FIX_N > 1) ? $clog2(FIX_N) : 1;
  localparam logic [FIX_W-1:0] FIX_LAST = FIX_W'(FIX_N - 1);

  loader_state_t    state;
  logic [15:0]      addr;
  logic [FIX_W-1:0] fix_cnt;
  logic             dl_prev;
  logic             end_pend;
  logic             active;

  logic             prg_dl_c;
  logic             prg_wr_c;
  logic             fall_c;
  logic             pending;
  logic             load_c;
  logic [15:0]      load_addr_c;
  logic [7:0]       load_data_c;

  assign prg_dl_c = ioctl_download && (ioctl_index == PRG_INDEX);
  assign prg_wr_c = ioctl_wr && (ioctl_index == PRG_INDEX);
  assign fall_c   = dl_prev && !prg_dl_c;

  // Write request source: file data in DATA, pointer bytes for the first and later fixups.
  always_comb begin
    load_c      = 1'b0;
    load_addr_c = addr;
    load_data_c = ioctl_dout;
    case (state)
      DATA: begin
        if (!pending) begin
          if (fall_c || end_pend) begin
            load_c      = 1'b1;
            load_addr_c = PTR_BASE;
            load_data_c = fix_byte(addr, 1'b0);
          end else if (prg_wr_c && (addr < RAM_TOP)) begin
            load_c = 1'b1;
          end
        end
      end
      FIX: begin
        if (!pending && !prg_dl_c && (fix_cnt != FIX_LAST)) begin
          load_c      = 1'b1;
          load_addr_c = PTR_BASE + 16'(fix_cnt) + 16'd1;
          load_data_c = fix_byte(addr, !fix_cnt[0]);
        end
      end
      default: ;
    endcase
  end

  // Sequencer: header capture, data streaming, pointer fixups and hand-back to the CPU.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= 16'h0000;
      fix_cnt  <= '0;
      dl_prev  <= 1'b0;
      end_pend <= 1'b0;
      active   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      dl_prev <= prg_dl_c;
      case (state)
        IDLE: begin
          if (prg_dl_c) begin
            state    <= HDR;
            overflow <= 1'b0;
            active   <= 1'b1;
            end_pend <= 1'b0;
          end
        end
        HDR: begin
          if (fall_c) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (prg_wr_c && !pending) begin
            if (ioctl_addr == 25'd0) begin
              addr[7:0] <= ioctl_dout;
            end else if (ioctl_addr == 25'd1) begin
              addr[15:8] <= ioctl_dout;
              state      <= DATA;
            end
          end
        end
        DATA: begin
          if (!pending && (fall_c || end_pend)) begin
            state    <= FIX;
            fix_cnt  <= '0;
            end_pend <= 1'b0;
          end else if (fall_c) begin
            end_pend <= 1'b1;
          end else if (prg_wr_c && !pending) begin
            if (addr < RAM_TOP) addr <= addr + 16'd1;
            else overflow <= 1'b1;
          end
        end
        FIX: begin
          if (prg_dl_c) begin
            state    <= HDR;
            overflow <= 1'b0;
            end_pend <= 1'b0;
          end else if (!pending) begin
            if (fix_cnt == FIX_LAST) state <= DONE;
            else fix_cnt <= fix_cnt + FIX_W'(1);
          end
        end
        DONE: begin
          if (prg_dl_c) begin
            state    <= HDR;
            overflow <= 1'b0;
            end_pend <= 1'b0;
          end else begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = active;
  assign cpu_hold = active;

  loader_dma_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (load_c),
    .load_addr  (load_addr_c),
    .load_data  (load_data_c),
    .ack        (dma_ack),
    .dma_addr   (dma_addr),
    .dma_din    (dma_din),
    .dma_we     (dma_we),
    .pending    (pending),
    .ioctl_wait (ioctl_wait)
  );

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader: HPS byte model, write log, per-scenario expectations.
module tb_prg_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        dma_ack;
  logic        cpu_hold;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];

  prg_loader dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dma_addr       (dma_addr),
    .dma_din        (dma_din),
    .dma_we         (dma_we),
    .dma_ack        (dma_ack),
    .cpu_hold       (cpu_hold),
    .busy           (busy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && dma_we && dma_ack) begin
      log_addr.push_back(dma_addr);
      log_data.push_back(dma_din);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'h00;
    ioctl_wr = 1'b0;
    ioctl_addr = 25'd0;
    ioctl_dout = 8'h00;
    dma_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_byte(input int off, input logic [7:0] d);
    int n = 0;
    ioctl_addr = 25'(off);
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    while (ioctl_wait && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (ioctl_wait !== 1'b0) begin
      errors++;
      $display("FAIL send_byte_wait off=%0d: ioctl_wait=%b required 0", off, ioctl_wait);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ioctl_wait, dma_we, cpu_hold, busy, overflow} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: wait/we/hold/busy/ovf=%b required 00000",
               {ioctl_wait, dma_we, cpu_hold, busy, overflow});
    end
    checks++;
    if (dma_addr !== 16'h0000 || dma_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_dma_bus: addr=%h din=%h required 0000 00", dma_addr, dma_din);
    end
  endtask

  task automatic test_basic();
    logic [15:0] ea [9] = '{16'h0401, 16'h0402, 16'h0403, 16'h002A, 16'h002B,
                            16'h002C, 16'h002D, 16'h002E, 16'h002F};
    logic [7:0]  ed [9] = '{8'hAA, 8'hBB, 8'hCC, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};
    int n;
    apply_reset();
    dma_ack = 1'b1;
    start_dl(8'h41);
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: hold=%b busy=%b required 1 1", cpu_hold, busy);
    end
    send_byte(0, 8'h01);
    send_byte(1, 8'h04);
    send_byte(2, 8'hAA);
    send_byte(3, 8'hBB);
    send_byte(4, 8'hCC);
    ioctl_download = 1'b0;
    tick();
    checks++;
    if (dma_we !== 1'b1 || dma_addr !== 16'h002A) begin
      errors++;
      $display("FAIL basic_fix_first: we=%b addr=%h required 1 002a", dma_we, dma_addr);
    end
    n = 1;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 14) begin
      errors++;
      $display("FAIL basic_fix_duration: idle at cycle %0d required 14", n);
    end
    checks++;
    if (log_addr.size() !== 9) begin
      errors++;
      $display("FAIL basic_write_count: %0d required 9", log_addr.size());
    end
    for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL basic_write[%0d]: %h=%h required %h=%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (overflow !== 1'b0 || cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_flags: ovf=%b hold=%b required 0 0", overflow, cpu_hold);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ea [8] = '{16'h7FFE, 16'h7FFF, 16'h002A, 16'h002B,
                            16'h002C, 16'h002D, 16'h002E, 16'h002F};
    logic [7:0]  ed [8] = '{8'h11, 8'h22, 8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80};
    apply_reset();
    dma_ack = 1'b1;
    start_dl(8'h41);
    send_byte(0, 8'hFE);
    send_byte(1, 8'h7F);
    send_byte(2, 8'h11);
    send_byte(3, 8'h22);
    send_byte(4, 8'h33);
    send_byte(5, 8'h44);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b required 1", overflow);
    end
    ioctl_download = 1'b0;
    wait_idle("ovf");
    checks++;
    if (log_addr.size() !== 8) begin
      errors++;
      $display("FAIL ovf_write_count: %0d required 8", log_addr.size());
    end
    for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL ovf_write[%0d]: %h=%h required %h=%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: overflow=%b required 1", overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] ea [7] = '{16'h1000, 16'h002A, 16'h002B, 16'h002C, 16'h002D, 16'h002E, 16'h002F};
    logic [7:0]  ed [7] = '{8'h5A, 8'h01, 8'h10, 8'h01, 8'h10, 8'h01, 8'h10};
    apply_reset();
    start_dl(8'h41);
    send_byte(0, 8'h00);
    send_byte(1, 8'h10);
    ioctl_addr = 25'd2;
    ioctl_dout = 8'h5A;
    ioctl_wr = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dma_we !== 1'b1 || ioctl_wait !== 1'b1 || dma_addr !== 16'h1000 || dma_din !== 8'h5A) begin
        errors++;
        $display("FAIL bp_hold[%0d]: we=%b wait=%b %h=%h required 1 1 1000=5a",
                 i, dma_we, ioctl_wait, dma_addr, dma_din);
      end
      if (i == 2) begin
        ioctl_addr = 25'd3;
        ioctl_dout = 8'h77;
        ioctl_wr = 1'b1;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    dma_ack = 1'b1;
    tick();
    checks++;
    if (dma_we !== 1'b0 || ioctl_wait !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: we=%b wait=%b required 0 0", dma_we, ioctl_wait);
    end
    ioctl_download = 1'b0;
    wait_idle("bp");
    checks++;
    if (log_addr.size() !== 7) begin
      errors++;
      $display("FAIL bp_write_count: %0d required 7", log_addr.size());
    end
    for (int i = 0; i < 7 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL bp_write[%0d]: %h=%h required %h=%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_short_header();
    apply_reset();
    dma_ack = 1'b1;
    start_dl(8'h41);
    send_byte(0, 8'h01);
    ioctl_download = 1'b0;
    wait_idle("short");
    tick();
    checks++;
    if (log_addr.size() !== 0 || cpu_hold !== 1'b0 || dma_we !== 1'b0) begin
      errors++;
      $display("FAIL short_no_write: writes=%0d hold=%b we=%b required 0 0 0",
               log_addr.size(), cpu_hold, dma_we);
    end
  endtask

  task automatic test_reset_in_fix();
    apply_reset();
    start_dl(8'h41);
    send_byte(0, 8'h00);
    send_byte(1, 8'h20);
    ioctl_download = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (dma_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rstfix_pending: we=%b busy=%b required 1 1", dma_we, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({ioctl_wait, dma_we, cpu_hold, busy, overflow} !== 5'b00000 ||
        dma_addr !== 16'h0000 || dma_din !== 8'h00) begin
      errors++;
      $display("FAIL rstfix_outputs: flags=%b addr=%h din=%h required 00000 0000 00",
               {ioctl_wait, dma_we, cpu_hold, busy, overflow}, dma_addr, dma_din);
    end
    reset = 1'b0;
    dma_ack = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (log_addr.size() !== 0 || busy !== 1'b0 || dma_we !== 1'b0) begin
      errors++;
      $display("FAIL rstfix_idle: writes=%0d busy=%b we=%b required 0 0 0",
               log_addr.size(), busy, dma_we);
    end
  endtask

  task automatic test_tap();
    apply_reset();
    dma_ack = 1'b1;
    start_dl(8'h01);
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(8'h30 + i);
      ioctl_wr = 1'b1;
      tick();
      checks++;
      if (dma_we !== 1'b0 || ioctl_wait !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL tap_ignored[%0d]: we=%b wait=%b busy=%b required 0 0 0",
                 i, dma_we, ioctl_wait, busy);
      end
      ioctl_wr = 1'b0;
      tick();
    end
    ioctl_download = 1'b0;
    tick();
    tick();
    checks++;
    if (log_addr.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tap_end: writes=%0d busy=%b required 0 0", log_addr.size(), busy);
    end
  endtask

  task automatic test_restart_in_fix();
    logic [15:0] ea [9] = '{16'h002A, 16'h002B, 16'h0600, 16'h002A, 16'h002B,
                            16'h002C, 16'h002D, 16'h002E, 16'h002F};
    logic [7:0]  ed [9] = '{8'h00, 8'h05, 8'h9A, 8'h01, 8'h06, 8'h01, 8'h06, 8'h01, 8'h06};
    apply_reset();
    dma_ack = 1'b1;
    start_dl(8'h41);
    send_byte(0, 8'h00);
    send_byte(1, 8'h05);
    ioctl_download = 1'b0;
    tick();
    tick();
    tick();
    ioctl_download = 1'b1;
    tick();
    send_byte(0, 8'h00);
    send_byte(1, 8'h06);
    send_byte(2, 8'h9A);
    ioctl_download = 1'b0;
    wait_idle("restart");
    checks++;
    if (log_addr.size() !== 9) begin
      errors++;
      $display("FAIL restart_write_count: %0d required 9", log_addr.size());
    end
    for (int i = 0; i < 9 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
        errors++;
        $display("FAIL restart_write[%0d]: %h=%h required %h=%h", i, log_addr[i], log_data[i], ea[i], ed[i]);
      end
    end
  endtask

  initial begin
    apply_reset();
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_short_header();
    test_reset_in_fix();
    test_tap();
    test_restart_in_fix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
